// File: rtl/lvds_frame_sync_pkg.sv
// Shared constants and helpers for the LVDS frame-clock alignment logic.
// The defaults are also used by the TX serializer block.
package lvds_frame_sync_pkg;

   localparam int DEFAULT_FRAME_CYCLES   = 16;
   localparam int DEFAULT_LOCK_FRAMES    = 512;
   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   localparam int TCNT_W = 7;
   localparam int LOCK_W = 10;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'd0,
      EDGE_GOOD = 2'd1,
      EDGE_BAD  = 2'd2
   } edge_class_e;

   // A rise is good only when it lands exactly one frame after the previous wrap.
   function automatic edge_class_e classify_edge(input logic rise, input logic at_last_phase);
      if (!rise)
         return EDGE_NONE;
      else if (at_last_phase)
         return EDGE_GOOD;
      else
         return EDGE_BAD;
   endfunction

endpackage

// File: rtl/lvds_frame_sync_edge_detect.sv
// Three-flop synchronizer for the frame clock plus rising-edge detect.
// The frame clock is only ever treated as data here.
module sync_edge_detect (
   input  logic i_ddr_clk,
   input  logic i_rst,
   input  logic i_sys_clk,
   output logic o_rise
);

   logic [2:0] sync_reg;

   always_ff @(posedge i_ddr_clk or posedge i_rst) begin
      if (i_rst)
         sync_reg <= 3'b000;
      else
         sync_reg <= {sync_reg[1:0], i_sys_clk};
   end

   assign o_rise = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/lvds_frame_sync.sv
// Phase-locks a free-running frame strobe to the frame clock and reports
// lock once enough consecutive exact-period frame edges have been seen.
module lvds_frame_sync
   import lvds_frame_sync_pkg::*;
#(
   parameter int FRAME_CYCLES   = DEFAULT_FRAME_CYCLES,
   parameter int LOCK_FRAMES    = DEFAULT_LOCK_FRAMES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic i_ddr_clk,
   input  logic i_rst,
   input  logic i_sys_clk,
   output logic o_data_sbe_ddr,
   output logic o_lvds_ready_ddr
);

   localparam int PHASE_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FRAME_CYCLES - 1);
   localparam logic [TCNT_W-1:0]  TCNT_SAT   = TCNT_W'(TIMEOUT_CYCLES);
   localparam logic [TCNT_W-1:0]  TCNT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [LOCK_W-1:0]  LOCK_SAT   = LOCK_W'(LOCK_FRAMES);

   logic               rise;
   logic               wrap;
   logic               timeout;
   edge_class_e        edge_class;
   logic [PHASE_W-1:0] phase_reg, phase_next;
   logic [TCNT_W-1:0]  tcnt_reg, tcnt_next;
   logic [LOCK_W-1:0]  lock_reg, lock_next;
   logic               sbe_reg, ready_reg;

   sync_edge_detect u_sync (
      .i_ddr_clk (i_ddr_clk),
      .i_rst     (i_rst),
      .i_sys_clk (i_sys_clk),
      .o_rise    (rise)
   );

   always_comb begin
      // Any rise realigns the phase, so an early edge gives one strobe, not two.
      wrap       = rise | (phase_reg == PHASE_LAST);
      phase_next = wrap ? '0 : phase_reg + 1'b1;
      edge_class = classify_edge(rise, phase_reg == PHASE_LAST);
      timeout    = ~rise & (tcnt_reg == TCNT_LAST);

      if (rise)
         tcnt_next = '0;
      else if (tcnt_reg == TCNT_SAT)
         tcnt_next = tcnt_reg;
      else
         tcnt_next = tcnt_reg + 1'b1;

      lock_next = lock_reg;
      if (edge_class == EDGE_BAD || timeout)
         lock_next = '0;
      else if (edge_class == EDGE_GOOD && lock_reg != LOCK_SAT)
         lock_next = lock_reg + 1'b1;
   end

   always_ff @(posedge i_ddr_clk or posedge i_rst) begin
      if (i_rst) begin
         phase_reg <= '0;
         tcnt_reg  <= '0;
         lock_reg  <= '0;
         sbe_reg   <= 1'b0;
         ready_reg <= 1'b0;
      end else begin
         phase_reg <= phase_next;
         tcnt_reg  <= tcnt_next;
         lock_reg  <= lock_next;
         sbe_reg   <= wrap;
         ready_reg <= (lock_next == LOCK_SAT);
      end
   end

   assign o_data_sbe_ddr   = sbe_reg;
   assign o_lvds_ready_ddr = ready_reg;

endmodule

// File: tb/tb_lvds_frame_sync.sv
// Directed bench for lvds_frame_sync: reset, lock, jitter, clock loss,
// wrong frame rate and counter saturation, with hand-derived strobe timing.
module tb_lvds_frame_sync;

   logic i_ddr_clk = 1'b0;
   logic i_rst     = 1'b1;
   logic i_sys_clk = 1'b0;
   logic o_data_sbe_ddr;
   logic o_lvds_ready_ddr;

   int checks    = 0;
   int errors    = 0;
   int sbe_count = 0;
   int snap      = 0;

   lvds_frame_sync dut (
      .i_ddr_clk        (i_ddr_clk),
      .i_rst            (i_rst),
      .i_sys_clk        (i_sys_clk),
      .o_data_sbe_ddr   (o_data_sbe_ddr),
      .o_lvds_ready_ddr (o_lvds_ready_ddr)
   );

   initial forever #5 i_ddr_clk = ~i_ddr_clk;

   always @(negedge i_ddr_clk) begin
      if (o_data_sbe_ddr === 1'b1)
         sbe_count <= sbe_count + 1;
   end

   task automatic step();
      @(posedge i_ddr_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      i_rst     = 1'b1;
      i_sys_clk = 1'b0;
      step();
      step();
      i_rst = 1'b0;
   endtask

   // One frame-clock period starting with a rise; the rise set just after an
   // edge shows up as a strobe 3 steps later. Ready may change at that step.
   task automatic run_period(input string tag, input int hi, input int lo,
                             input int sbe_a, input int sbe_b,
                             input logic rdy_pre, input logic rdy_post);
      i_sys_clk = 1'b1;
      for (int i = 1; i <= hi + lo; i++) begin
         step();
         check({tag, " sbe"}, o_data_sbe_ddr, (i == sbe_a) || (i == sbe_b));
         check({tag, " ready"}, o_lvds_ready_ddr, (i < 3) ? rdy_pre : rdy_post);
         if (i == hi)
            i_sys_clk = 1'b0;
      end
   endtask

   initial begin
      // Reset state and free-running strobe with no frame clock
      step();
      step();
      check("reset sbe", o_data_sbe_ddr, 1'b0);
      check("reset ready", o_lvds_ready_ddr, 1'b0);
      i_rst = 1'b0;
      for (int i = 1; i <= 48; i++) begin
         step();
         check("freerun sbe", o_data_sbe_ddr, (i % 16) == 0);
         check("freerun ready", o_lvds_ready_ddr, 1'b0);
      end
      #1 i_rst = 1'b1;
      #1 check("async reset sbe", o_data_sbe_ddr, 1'b0);
      check("async reset ready", o_lvds_ready_ddr, 1'b0);
      $display("scenario reset: checks %0d errors %0d", checks, errors);

      // Lock: first edge only aligns, 512 good edges then assert ready
      do_reset();
      run_period("first edge", 8, 8, 3, 0, 1'b0, 1'b0);
      snap = sbe_count;
      for (int p = 2; p <= 512; p++)
         run_period("lock wait", 8, 8, 3, 0, 1'b0, 1'b0);
      run_period("lock 512th", 8, 8, 3, 0, 1'b0, 1'b1);
      check("lock strobe count", sbe_count - snap, 512);
      $display("scenario lock: checks %0d errors %0d", checks, errors);

      // Jitter: a 15-cycle period makes the following edge bad
      run_period("jitter short", 8, 7, 3, 0, 1'b1, 1'b1);
      run_period("jitter bad edge", 8, 8, 3, 0, 1'b1, 1'b0);
      for (int p = 1; p <= 511; p++)
         run_period("relock wait", 8, 8, 3, 0, 1'b0, 1'b0);
      run_period("relock", 8, 8, 3, 0, 1'b0, 1'b1);
      $display("scenario jitter: checks %0d errors %0d", checks, errors);

      // Clock loss: last rise registered at step 3, timeout 64 steps later
      i_sys_clk = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         step();
         check("loss sbe", o_data_sbe_ddr, (i >= 3) && (((i - 3) % 16) == 0));
         check("loss ready", o_lvds_ready_ddr, i < 67);
         if (i == 8)
            i_sys_clk = 1'b0;
      end
      $display("scenario clock loss: checks %0d errors %0d", checks, errors);

      // Wrong rate: 20-cycle period, strobe at each edge and at each wrap
      do_reset();
      snap = sbe_count;
      for (int p = 1; p <= 600; p++)
         run_period("wrong rate", 10, 10, 3, 19, 1'b0, 1'b0);
      check("wrong rate strobe count", sbe_count - snap, 1200);
      $display("scenario wrong rate: checks %0d errors %0d", checks, errors);

      // Saturation: well over 1024 good frames, ready must never drop
      do_reset();
      run_period("sat first edge", 8, 8, 3, 0, 1'b0, 1'b0);
      for (int p = 2; p <= 512; p++)
         run_period("sat lock wait", 8, 8, 3, 0, 1'b0, 1'b0);
      run_period("sat lock 512th", 8, 8, 3, 0, 1'b0, 1'b1);
      for (int p = 1; p <= 600; p++)
         run_period("sat hold", 8, 8, 3, 0, 1'b1, 1'b1);
      check("pre reset ready", o_lvds_ready_ddr, 1'b1);
      #1 i_rst = 1'b1;
      #1 check("async reset locked ready", o_lvds_ready_ddr, 1'b0);
      check("async reset locked sbe", o_data_sbe_ddr, 1'b0);
      step();
      i_rst = 1'b0;
      $display("scenario saturation: checks %0d errors %0d", checks, errors);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lvds_frame_sync.md
# lvds_frame_sync

Aligns the LVDS DDR-clock domain to the lower-rate frame clock, and reports whether that frame clock is present and stable. It produces a one-cycle sample/frame strobe every `FRAME_CYCLES` DDR cycles, with the strobe phase locked to the rising edges of the frame clock. A ready flag gates the LVDS TX serializer and its sync state machine. Everything runs on the DDR clock; the frame clock is treated as an asynchronous data input.

## Interface
Parameters:
- `FRAME_CYCLES`, default 16: DDR cycles per frame (32-bit word at 2 bits/cycle).
- `LOCK_FRAMES`, default 512: consecutive good frame edges required before ready asserts.
- `TIMEOUT_CYCLES`, default 64: DDR cycles without a frame edge that count as clock loss.

Ports:
- `i_ddr_clk`  in  1: the single clock; all logic is on its rising edge.
- `i_rst`  in  1: asynchronous, active-high reset.
- `i_sys_clk`  in  1: frame clock, sampled as asynchronous data (it is not used as a clock).
- `o_data_sbe_ddr`  out  1: registered one-cycle frame strobe.
- `o_lvds_ready_ddr`  out  1: registered flag, high while the frame clock is locked.

## Operation
- **Synchronizer:** 3-flop shift register `s[2:0]`, with `s[0] <= i_sys_clk`.
  - `edge = s[1] & ~s[2]` (rising edge of the frame clock).
- **Phase counter:** `phase`, width `$clog2(FRAME_CYCLES)`.
  - `wrap = edge | (phase == FRAME_CYCLES-1)`.
  - `phase <= wrap ? 0 : phase+1`.
  - `o_data_sbe_ddr <= wrap`.
  - The strobe free-runs even when unlocked or when the frame clock is lost.
- **Edge classification:**
  - Good edge: `edge && phase == FRAME_CYCLES-1`, meaning the interval since the last wrap is exactly `FRAME_CYCLES`.
  - Bad edge: `edge` at any other phase. An early edge realigns the phase immediately and yields exactly one strobe.
- **Timeout counter:** 7 bits.
  - Cleared on `edge`; otherwise increments, saturating at `TIMEOUT_CYCLES`.
  - `timeout = ~edge && tcnt == TIMEOUT_CYCLES-1`.
- **Lock counter:** 10 bits.
  - A good edge increments it, saturating at `LOCK_FRAMES`.
  - A bad edge or `timeout` clears it to 0. Bad edge/timeout takes priority.
  - `o_lvds_ready_ddr <= (lock_next == LOCK_FRAMES)`, so ready drops in the same cycle the counter clears.
- **Reset:** all registers are 0, so `o_data_sbe_ddr=0` and `o_lvds_ready_ddr=0`. Reset mid-operation drops ready at once, and relock requires `LOCK_FRAMES` fresh good edges.
- **Edge after reset:** the first edge is normally bad (phase arbitrary). It serves only for alignment.

## Timing
- Frame-clock rise sampled at DDR edge k: `s[0]` updates at k, `s[1]` at k+1. `o_data_sbe_ddr` is high from edge k+2 to k+3, and `phase` is 0 from k+2.
- Steady state: the strobe is high exactly 1 of every `FRAME_CYCLES` cycles, coincident with the good edge.
- Ready asserts at the DDR edge where the `LOCK_FRAMES`-th consecutive good edge is registered.
- Ready deasserts at the edge registering a bad edge, or `TIMEOUT_CYCLES` cycles after the last edge.
- Frame clock stuck high or low: no edges, so timeout occurs and ready stays 0 until relock.
- Constraint: the frame-clock high and low times must each be at least 2 DDR cycles.

## Structure
- Shared package holds the default constants `FRAME_CYCLES`, `LOCK_FRAMES` and `TIMEOUT_CYCLES`, reused by the TX block.
- One natural sub-module: `sync_edge_detect`, the 3-flop synchronizer plus rising-edge detect.
- The rest is counters and stays flat.

## Test plan
- **Reset:** assert `i_rst` asynchronously mid-frame → both outputs are 0 immediately; after release, with no `i_sys_clk` activity, the strobe pulses every 16 cycles and ready stays 0.
- **Lock:** drive `i_sys_clk` with a 16-cycle period (8 high / 8 low) → strobes coincide 2 cycles after each sampled rise; ready rises on the 512th good edge (first edge excluded); strobe count equals the number of frames.
- **Jitter:** once locked, make one period 15 cycles → ready falls on that edge, the strobe realigns without a duplicate, and ready rises again after 512 more good edges.
- **Clock loss:** once locked, hold `i_sys_clk` low → ready falls exactly 64 cycles after the last edge, and strobes continue every 16 cycles.
- **Wrong rate:** a 20-cycle period → every edge is bad and ready never asserts; strobes occur at the counter wrap (cycle 16) and at each edge.
- **Saturation:** lock for more than 1024 frames → lock and timeout counters do not wrap, and ready stays 1 continuously.
